// File: rtl/slave_arbiter_2to1_pkg.sv
// Shared types for the 2-to-1 slave arbiter: section/grant enums and default constants.
// scam_model_types carries the generator-wide data width that the arbiter defaults follow.
package scam_model_types;
  localparam int unsigned SCAM_DATA_W = 32;
endpackage

package slave_arbiter_2to1_types;
  import scam_model_types::*;

  typedef enum logic {ARB_IDLE, ARB_SEND} Sections;
  typedef enum logic {GRANT_A, GRANT_B} Grant;

  localparam int unsigned DEFAULT_DATA_W    = SCAM_DATA_W;
  localparam int unsigned DEFAULT_CNT_W     = 16;
  localparam int unsigned DEFAULT_RESET_VAL = 1337;
endpackage

// File: rtl/slave_arbiter_2to1_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester
// that did not win last time is chosen.
module rr_pick2
  import slave_arbiter_2to1_types::*;
(
  input  logic req_a,
  input  logic req_b,
  input  Grant last_grant,
  output logic grant_valid,
  output Grant grant
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant       = GRANT_A;
    if (req_a && req_b) begin
      grant = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (req_b) begin
      grant = GRANT_B;
    end
  end

endmodule

// File: rtl/slave_arbiter_2to1.sv
// Round-robin arbiter sharing one registered blocking output between two requesters.
// Define ARB_STATS_EN to build saturating per-requester grant counters.
module slave_arbiter_2to1
  import slave_arbiter_2to1_types::*;
#(
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(DEFAULT_RESET_VAL),
  parameter int unsigned       CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_in,
  input  logic              s_in_sync,
  output logic              s_in_notify,
  input  logic [DATA_W-1:0] s_in2,
  input  logic              s_in2_sync,
  output logic              s_in2_notify,
  output logic [DATA_W-1:0] s_out,
  output logic              s_out_notify,
  input  logic              s_out_sync,
  output logic [CNT_W-1:0]  grant_cnt_a,
  output logic [CNT_W-1:0]  grant_cnt_b
);

  Sections           section_q, section_d;
  Grant              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] s_out_q, s_out_d;
  logic              s_out_notify_q, s_out_notify_d;
  logic              a_notify_q, a_notify_d;
  logic              b_notify_q, b_notify_d;
  logic              pick_valid;
  Grant              pick;

  rr_pick2 u_pick (
    .req_a       (s_in_sync),
    .req_b       (s_in2_sync),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  always_comb begin
    section_d      = section_q;
    last_grant_d   = last_grant_q;
    s_out_d        = s_out_q;
    s_out_notify_d = s_out_notify_q;
    a_notify_d     = 1'b0;
    b_notify_d     = 1'b0;
    case (section_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          s_out_d        = (pick == GRANT_A) ? s_in : s_in2;
          s_out_notify_d = 1'b1;
          a_notify_d     = (pick == GRANT_A);
          b_notify_d     = (pick == GRANT_B);
          last_grant_d   = pick;
          section_d      = ARB_SEND;
        end
      end
      ARB_SEND: begin
        // Requester syncs are ignored here; they stay pending until back in idle.
        if (s_out_sync) begin
          s_out_notify_d = 1'b0;
          section_d      = ARB_IDLE;
        end
      end
      default: section_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_q      <= ARB_IDLE;
      last_grant_q   <= GRANT_B;
      s_out_q        <= RESET_VAL;
      s_out_notify_q <= 1'b0;
      a_notify_q     <= 1'b0;
      b_notify_q     <= 1'b0;
    end else begin
      section_q      <= section_d;
      last_grant_q   <= last_grant_d;
      s_out_q        <= s_out_d;
      s_out_notify_q <= s_out_notify_d;
      a_notify_q     <= a_notify_d;
      b_notify_q     <= b_notify_d;
    end
  end

  assign s_out        = s_out_q;
  assign s_out_notify = s_out_notify_q;
  assign s_in_notify  = a_notify_q;
  assign s_in2_notify = b_notify_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             grant_a_evt, grant_b_evt;

  assign grant_a_evt = (section_q == ARB_IDLE) && pick_valid && (pick == GRANT_A);
  assign grant_b_evt = (section_q == ARB_IDLE) && pick_valid && (pick == GRANT_B);

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_a_evt && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (grant_b_evt && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`else
  assign grant_cnt_a = '0;
  assign grant_cnt_b = '0;
`endif

endmodule

// File: tb/tb_slave_arbiter_2to1.sv
// Self-checking bench for slave_arbiter_2to1: directed scenarios followed by
// random traffic, compared each cycle against a transaction-level model.
module tb_slave_arbiter_2to1;
  localparam int unsigned       DATA_W    = 32;
  localparam int unsigned       CNT_W     = 4;
  localparam logic [DATA_W-1:0] RESET_VAL = 32'd1337;
  localparam int                CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] s_in = '0;
  logic              s_in_sync = 1'b0;
  logic              s_in_notify;
  logic [DATA_W-1:0] s_in2 = '0;
  logic              s_in2_sync = 1'b0;
  logic              s_in2_notify;
  logic [DATA_W-1:0] s_out;
  logic              s_out_notify;
  logic              s_out_sync = 1'b0;
  logic [CNT_W-1:0]  grant_cnt_a;
  logic [CNT_W-1:0]  grant_cnt_b;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one word in flight at most, alternating winner on ties.
  bit                mWordHeld;
  bit                mBWonLast;
  logic [DATA_W-1:0] mOut;
  bit                mAckA, mAckB;
  int                mGrantsA, mGrantsB;

  always #5 clk = ~clk;

  slave_arbiter_2to1 #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_in         (s_in),
    .s_in_sync    (s_in_sync),
    .s_in_notify  (s_in_notify),
    .s_in2        (s_in2),
    .s_in2_sync   (s_in2_sync),
    .s_in2_notify (s_in2_notify),
    .s_out        (s_out),
    .s_out_notify (s_out_notify),
    .s_out_sync   (s_out_sync),
    .grant_cnt_a  (grant_cnt_a),
    .grant_cnt_b  (grant_cnt_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mWordHeld = 1'b0;
    mBWonLast = 1'b1;
    mOut      = RESET_VAL;
    mAckA     = 1'b0;
    mAckB     = 1'b0;
    mGrantsA  = 0;
    mGrantsB  = 0;
  endtask

  task automatic modelStep(input bit aS, input logic [DATA_W-1:0] aD,
                           input bit bS, input logic [DATA_W-1:0] bD, input bit rdy);
    bit aWins;
    mAckA = 1'b0;
    mAckB = 1'b0;
    if (!mWordHeld) begin
      if (aS || bS) begin
        aWins     = aS && (!bS || mBWonLast);
        mOut      = aWins ? aD : bD;
        mWordHeld = 1'b1;
        mBWonLast = !aWins;
        if (aWins) begin
          mAckA    = 1'b1;
          mGrantsA = (mGrantsA >= CNT_MAX) ? CNT_MAX : mGrantsA + 1;
        end else begin
          mAckB    = 1'b1;
          mGrantsB = (mGrantsB >= CNT_MAX) ? CNT_MAX : mGrantsB + 1;
        end
      end
    end else if (rdy) begin
      mWordHeld = 1'b0;
    end
  endtask

  task automatic compareAll(input string ctx);
    int expA, expB;
`ifdef ARB_STATS_EN
    expA = mGrantsA;
    expB = mGrantsB;
`else
    expA = 0;
    expB = 0;
`endif
    checkOutput({ctx, ".s_out"}, 64'(s_out), 64'(mOut));
    checkOutput({ctx, ".s_out_notify"}, 64'(s_out_notify), 64'(mWordHeld));
    checkOutput({ctx, ".s_in_notify"}, 64'(s_in_notify), 64'(mAckA));
    checkOutput({ctx, ".s_in2_notify"}, 64'(s_in2_notify), 64'(mAckB));
    checkOutput({ctx, ".grant_cnt_a"}, 64'(grant_cnt_a), 64'(expA));
    checkOutput({ctx, ".grant_cnt_b"}, 64'(grant_cnt_b), 64'(expB));
  endtask

  task automatic applyStimulus(input bit aS, input logic [DATA_W-1:0] aD,
                               input bit bS, input logic [DATA_W-1:0] bD,
                               input bit rdy, input string ctx);
    s_in       = aD;
    s_in_sync  = aS;
    s_in2      = bD;
    s_in2_sync = bS;
    s_out_sync = rdy;
    @(posedge clk);
    modelStep(aS, aD, bS, bD, rdy);
    #1;
    compareAll(ctx);
  endtask

  // Asserts reset between clock edges and releases it before the next edge.
  task automatic pulseReset(input string ctx);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    compareAll(ctx);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expSat;
    modelReset();
    #12;
    compareAll("reset");
    rst = 1'b1;

    // Reset while a word is stalled in the send section.
    applyStimulus(1'b1, 32'd5, 1'b0, '0, 1'b0, "rstSetup");
    applyStimulus(1'b0, 32'd5, 1'b0, '0, 1'b0, "rstHold");
    pulseReset("rstMid");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "noResend0");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "noResend1");
    applyStimulus(1'b1, 32'd99, 1'b0, '0, 1'b0, "idleAfterRst");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "drain");

    // Single requester A.
    applyStimulus(1'b1, 32'd42, 1'b0, '0, 1'b1, "onlyA.grant");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "onlyA.done");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "onlyA.idle");

    // Simultaneous requests from a fresh reset alternate A, B, A, B.
    pulseReset("rstAlt");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'd10, 1'b1, 32'd20, 1'b1, "alt");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "altDrain");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "altIdle");

    // Backpressure: B's word held while A waits.
    applyStimulus(1'b0, '0, 1'b1, 32'd7, 1'b0, "bp.grantB");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd3, 1'b0, '0, 1'b0, "bp.stall");
    applyStimulus(1'b1, 32'd3, 1'b0, '0, 1'b1, "bp.release");
    applyStimulus(1'b1, 32'd3, 1'b0, '0, 1'b1, "bp.grantA");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "bp.drain");

    // Counter saturation: 20 grants to A, 3 to B.
    pulseReset("rstStats");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(100 + i), 1'b0, '0, 1'b1, "statsA");
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "statsAIdle");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 32'(200 + i), 1'b1, "statsB");
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, "statsBIdle");
    end
`ifdef ARB_STATS_EN
    expSat = 15;
`else
    expSat = 0;
`endif
    checkOutput("cntA.saturated", 64'(grant_cnt_a), 64'(expSat));
    checkOutput("cntB.three", 64'(grant_cnt_b), 64'((expSat == 0) ? 0 : 3));

    // Random traffic.
    pulseReset("rstRand");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)), $urandom(),
                    bit'($urandom_range(0, 1)), $urandom(),
                    ($urandom_range(0, 3) != 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
